banco_registradores_mp: RTL
===========================

# banco_registradores_mp

Parametrised multi-port register file for the pipelined MIPS datapath, the successor of the single-cycle register bank. It provides configurable data width, register count and read-port count, two write ports with fixed priority, optional write-through bypass, and a per-register pending-write scoreboard so decode can detect RAW hazards. It sits between decode (reads, reservations) and writeback (writes), and exports a flattened dump of all registers for the debug/display path.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of registers; power of two, ≥ 2
- ADDR_WIDTH, $clog2(NUM_REGS), register address width
- NUM_READ, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads see stored value only

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  read data, same packing
- rd_busy  out  NUM_READ  1 = addressed register has an outstanding reservation
- wr_en  in  2  write enables, ports 0 and 1
- wr_addr  in  2*ADDR_WIDTH  write addresses
- wr_data  in  2*DATA_WIDTH  write data
- rsv_en  in  1  reserve the register at rsv_addr (instruction issued with that destination)
- rsv_addr  in  ADDR_WIDTH  destination being reserved
- dump  out  NUM_REGS*DATA_WIDTH  all stored values, register i at [i*DATA_WIDTH +: DATA_WIDTH]
- pending_count  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- Register 0: always reads 0, never written, never busy; writes/reservations to address 0 are ignored.
- Write: wr_en[p] with wr_addr[p] ≠ 0 stores wr_data[p] at the next edge and clears busy[wr_addr[p]].
- Both ports same address: port 1 wins (data); busy is cleared once.
- Reserve: rsv_en with rsv_addr ≠ 0 sets busy[rsv_addr] at the next edge. Reserving an already busy register leaves it busy (no nesting count).
- Reserve and write to same address in the same cycle: register takes write data, busy ends SET (newer producer wins).
- Read, BYPASS=0: rd_data = stored value; rd_busy = busy bit.
- Read, BYPASS=1: if an enabled write targets the read address this cycle, rd_data = that write data (port 1 over port 0) and rd_busy = 0; otherwise as BYPASS=0. Same-cycle reservation does not affect rd_busy.
- pending_count: registered population count of busy bits; updates on the same edge as busy.
- dump reflects stored values only (never bypassed).

## Timing
- Reset (reset_n low, asynchronous): all registers 0, all busy 0, pending_count 0; hence rd_data 0, rd_busy 0, dump 0 while held. Reset during an active write discards the write.
- Reads combinational, zero latency from rd_addr/wr_* to rd_data/rd_busy.
- Writes and reservations: one-cycle latency; visible in stored state, dump and pending_count after the rising edge.
- pending_count never exceeds NUM_REGS-1; net change per cycle in −2..+1.

## Structure
- Shared package regfile_pkg: default widths, REG_ZERO address constant, port-index constants for the write ports.
- One natural sub-module: regfile_scoreboard (busy bits, reserve/clear priority, pending_count); the data array, write priority and bypass muxes stay in the top.

## Test plan
- Reset: hold reset_n low mid-write of 0xDEADBEEF to r5 -> r5 = 0, dump all zero, pending_count 0 after release.
- Write r3 = 0x12345678 via port 0, read next cycle -> rd_data 0x12345678; write r0 = 0xFFFFFFFF -> r0 reads 0.
- Same-cycle conflict: port 0 writes r7 = 0x1, port 1 writes r7 = 0x2 -> r7 = 0x2, busy[7] cleared.
- BYPASS=1: write r4 = 0xA5A5A5A5 while reading r4 -> same-cycle rd_data 0xA5A5A5A5, rd_busy 0; BYPASS=0 -> old value.
- Scoreboard: reserve r9 -> rd_busy 1, pending_count 1; reserve r9 and write r9 together -> stays busy, count 1; write r9 -> busy 0, count 0.
- Parametrisation: NUM_REGS=16, DATA_WIDTH=16, NUM_READ=3 -> all three ports read independently, dump width 256.

Source files
------------

// File: rtl/banco_registradores_mp_pkg.sv
// Shared constants for the multi-port MIPS register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_READ   = 2;

  // Register 0 is hardwired to zero and can never be reserved.
  localparam int REG_ZERO  = 0;
  localparam int WR_PORT0  = 0;
  localparam int WR_PORT1  = 1;
  localparam int NUM_WRITE = 2;

endpackage

// File: rtl/banco_registradores_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports, reservations and debug dump.
interface banco_registradores_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
);

  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;
  logic [NUM_READ-1:0]             rd_busy;
  logic [NUM_WRITE-1:0]            wr_en;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
  logic                            rsv_en;
  logic [ADDR_WIDTH-1:0]           rsv_addr;
  logic [NUM_REGS*DATA_WIDTH-1:0]  dump;
  logic [ADDR_WIDTH:0]             pending_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, dump, pending_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, dump, pending_count
  );

endinterface

// File: rtl/banco_registradores_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_WRITE-1:0]            i_wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic                            i_rsv_en,
  input  logic [ADDR_WIDTH-1:0]           i_rsv_addr,
  output logic [NUM_REGS-1:0]             o_busy,
  output logic [ADDR_WIDTH:0]             o_pending_count
);

  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_WIDTH:0] r_count;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [ADDR_WIDTH:0] w_count_next;

  // Writes retire a producer, then a same-cycle reservation re-arms it (newer producer wins).
  always_comb begin
    w_busy_next = r_busy;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO)))
        w_busy_next[i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (i_rsv_en && (i_rsv_addr != ADDR_WIDTH'(REG_ZERO)))
      w_busy_next[i_rsv_addr] = 1'b1;
    w_busy_next[REG_ZERO] = 1'b0;
  end

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_count_next = w_count_next + {{ADDR_WIDTH{1'b0}}, w_busy_next[i]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
    end
  end

  assign o_busy          = r_busy;
  assign o_pending_count = r_count;

endmodule

// File: rtl/banco_registradores_mp.sv
// Multi-port register file for the pipelined MIPS datapath: two prioritised write ports,
// optional write-through bypass on every read port, and a RAW-hazard scoreboard.
module banco_registradores_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int BYPASS     = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  banco_registradores_mp_if.slave  bus
);

  logic [DATA_WIDTH-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]            w_busy;
  logic [NUM_READ*DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_READ-1:0]            w_rd_busy;

  regfile_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_wr_en         (bus.wr_en),
    .i_wr_addr       (bus.wr_addr),
    .i_rsv_en        (bus.rsv_en),
    .i_rsv_addr      (bus.rsv_addr),
    .o_busy          (w_busy),
    .o_pending_count (bus.pending_count)
  );

  // Port 1 is applied after port 0 so it wins a same-address collision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else begin
      if (bus.wr_en[WR_PORT0] &&
          (bus.wr_addr[WR_PORT0*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO)))
        r_regs[bus.wr_addr[WR_PORT0*ADDR_WIDTH +: ADDR_WIDTH]] <=
          bus.wr_data[WR_PORT0*DATA_WIDTH +: DATA_WIDTH];
      if (bus.wr_en[WR_PORT1] &&
          (bus.wr_addr[WR_PORT1*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO)))
        r_regs[bus.wr_addr[WR_PORT1*ADDR_WIDTH +: ADDR_WIDTH]] <=
          bus.wr_data[WR_PORT1*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Bypass scans write ports in ascending order so port 1 overrides port 0.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      w_rd_busy[k] = w_busy[bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (bus.wr_en[p] &&
              (bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
              (bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO))) begin
            w_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            w_rd_busy[k] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_rd_busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dump
    assign bus.dump[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

endmodule
